sprite_blit: RTL and testbench

SPRITE_BLIT -- requirements
Module: sprite_blit

---
 rtl/sprite_blit.sv | 169 ++++++++++++++++
 tb/tb_sprite_blit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit.sv
// Sprite blitter: copies a width x height ROM sprite, replicated by scaleX/scaleY, into a
// clipped framebuffer one destination pixel per cycle. Define SPRITE_BLIT_TRANSPARENT_EN for colour key 12'hF0F.
module sprite_blit #(
   parameter int ROM_AW = 16,
   parameter int FB_W   = 640,
   parameter int FB_H   = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [9:0]        posx,
   input  logic [8:0]        posy,
   input  logic [9:0]        width,
   input  logic [8:0]        height,
   input  logic [ROM_AW-1:0] memory_start_addr,
   input  logic [3:0]        scaleX,
   input  logic [3:0]        scaleY,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic              fb_we,
   output logic [18:0]       fb_addr,
   output logic [11:0]       fb_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t            state;
   logic [9:0]        posx_l;
   logic [9:0]        width_l;
   logic [3:0]        sx_l;
   logic [3:0]        sy_l;
   logic [13:0]       dst_w;
   logic [13:0]       dst_h;
   logic [13:0]       dx;
   logic [13:0]       dy;
   logic [3:0]        sx_cnt;
   logic [3:0]        sy_cnt;
   logic [9:0]        src_x;
   logic [ROM_AW-1:0] row_base;
   logic [14:0]       px;
   logic [13:0]       py;
   logic [18:0]       line_base;
   logic              we_q;
   logic              done_q;
   logic [18:0]       fb_addr_q;

   logic [3:0]        sx_eff;
   logic [3:0]        sy_eff;
   logic [13:0]       w_prod;
   logic [13:0]       h_prod;
   logic              last_col;
   logic              last_row;
   logic              clip;

   assign sx_eff   = (scaleX == 4'd0) ? 4'd1 : scaleX;
   assign sy_eff   = (scaleY == 4'd0) ? 4'd1 : scaleY;
   assign w_prod   = 14'(width) * 14'(sx_eff);
   assign h_prod   = 14'(height) * 14'(sy_eff);
   assign last_col = (dx == dst_w - 14'd1);
   assign last_row = (dy == dst_h - 14'd1);
   // px/py are wide enough never to wrap, so the clip test sees the true sum
   assign clip     = (px >= 15'(FB_W)) || (py >= 14'(FB_H));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         fb_addr_q <= '0;
         posx_l    <= '0;
         width_l   <= '0;
         sx_l      <= 4'd1;
         sy_l      <= 4'd1;
         dst_w     <= '0;
         dst_h     <= '0;
         dx        <= '0;
         dy        <= '0;
         sx_cnt    <= '0;
         sy_cnt    <= '0;
         src_x     <= '0;
         row_base  <= '0;
         px        <= '0;
         py        <= '0;
         line_base <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               we_q <= 1'b0;
               if (start) begin
                  posx_l    <= posx;
                  width_l   <= width;
                  sx_l      <= sx_eff;
                  sy_l      <= sy_eff;
                  dst_w     <= w_prod;
                  dst_h     <= h_prod;
                  dx        <= '0;
                  dy        <= '0;
                  sx_cnt    <= '0;
                  sy_cnt    <= '0;
                  src_x     <= '0;
                  row_base  <= memory_start_addr;
                  px        <= 15'(posx);
                  py        <= 14'(posy);
                  line_base <= 19'(32'(posy) * FB_W);
                  state     <= (w_prod == 14'd0 || h_prod == 14'd0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               // the pixel whose ROM address is on the bus now becomes next cycle's write
               we_q      <= ~clip;
               fb_addr_q <= line_base + 19'(px);
               if (last_col && last_row) begin
                  state <= DRAIN;
               end else if (last_col) begin
                  dx        <= '0;
                  px        <= 15'(posx_l);
                  src_x     <= '0;
                  sx_cnt    <= '0;
                  dy        <= dy + 14'd1;
                  py        <= py + 14'd1;
                  line_base <= line_base + 19'(FB_W);
                  if (sy_cnt == sy_l - 4'd1) begin
                     sy_cnt   <= '0;
                     row_base <= row_base + ROM_AW'(width_l);
                  end else begin
                     sy_cnt <= sy_cnt + 4'd1;
                  end
               end else begin
                  dx <= dx + 14'd1;
                  px <= px + 15'd1;
                  if (sx_cnt == sx_l - 4'd1) begin
                     sx_cnt <= '0;
                     src_x  <= src_x + 10'd1;
                  end else begin
                     sx_cnt <= sx_cnt + 4'd1;
                  end
               end
            end
            DRAIN: begin
               we_q   <= 1'b0;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               we_q  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = row_base + ROM_AW'(src_x);
   assign fb_addr   = fb_addr_q;
   assign fb_data   = we_q ? rom_data : 12'h000;
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign state_dbg = state;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
   assign fb_we = we_q && (rom_data != 12'hF0F);
`else
   assign fb_we = we_q;
`endif

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: reference pixel model feeding expected queues, checked
// against the ROM address bus and every framebuffer write.
module tb_sprite_blit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  posx;
   logic [8:0]  posy;
   logic [9:0]  width;
   logic [8:0]  height;
   logic [15:0] memory_start_addr;
   logic [3:0]  scaleX;
   logic [3:0]  scaleY;
   logic [15:0] rom_addr;
   logic [11:0] rom_data;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [11:0] fb_data;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   logic [11:0] rom [0:65535];
   logic [30:0] exp_q[$];
   logic [15:0] exp_rom_q[$];
   int          cyc;
   int          n_checks;
   int          n_pass;

   sprite_blit #(.ROM_AW(16), .FB_W(640), .FB_H(480)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .posx(posx), .posy(posy), .width(width), .height(height),
      .memory_start_addr(memory_start_addr), .scaleX(scaleX), .scaleY(scaleY),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset / synchronous ROM
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic build_model(input int px0, input int py0, input int w, input int h,
                              input int sx, input int sy, input int base);
      int sxe, sye, a;
      logic [11:0] d;
      logic keep;
      sxe = (sx == 0) ? 1 : sx;
      sye = (sy == 0) ? 1 : sy;
      exp_q.delete();
      exp_rom_q.delete();
      for (int dy = 0; dy < h * sye; dy++) begin
         for (int dx = 0; dx < w * sxe; dx++) begin
            a = (base + (dy / sye) * w + dx / sxe) % 65536;
            exp_rom_q.push_back(16'(a));
            if (px0 + dx < 640 && py0 + dy < 480) begin
               d = rom[a];
               keep = 1'b1;
`ifdef SPRITE_BLIT_TRANSPARENT_EN
               if (d == 12'hF0F) keep = 1'b0;
`endif
               if (keep) exp_q.push_back({19'((py0 + dy) * 640 + px0 + dx), d});
            end
         end
      end
   endtask

   task automatic drive_start(input int px0, input int py0, input int w, input int h,
                              input int sx, input int sy, input int base);
      posx = 10'(px0); posy = 9'(py0); width = 10'(w); height = 9'(h);
      scaleX = 4'(sx); scaleY = 4'(sy); memory_start_addr = 16'(base);
      start = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge of the done cycle (or after the budget).
   task automatic run_blit(input string name, input int px0, input int py0, input int w, input int h,
                           input int sx, input int sy, input int base,
                           input int exp_writes, input int exp_done, input bit perturb);
      int n, s, done_at, writes, first_we;
      n = w * ((sx == 0) ? 1 : sx) * h * ((sy == 0) ? 1 : sy);
      build_model(px0, py0, w, h, sx, sy, base);
      drive_start(px0, py0, w, h, sx, sy, base);
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      done_at = -1; writes = 0; first_we = -1;
      for (int k = 1; k <= n + 10; k++) begin
         if (k <= n && exp_rom_q.size() > 0) check({name, " rom_addr"}, 32'(rom_addr), 32'(exp_rom_q.pop_front()));
         if (fb_we) begin
            writes++;
            if (first_we < 0) first_we = cyc - s;
            if (exp_q.size() == 0) check({name, " extra_write"}, 32'(fb_addr), 32'hFFFF_FFFF);
            else check({name, " fb_write"}, 32'({fb_addr, fb_data}), 32'(exp_q.pop_front()));
         end
         if (done) begin
            done_at = cyc - s;
            check({name, " busy_at_done"}, 32'(busy), 32'd0);
            break;
         end
         if (perturb && k == 5) begin
            start = 1'b1; posx = posx + 10'd200; posy = posy + 9'd3;
         end
         if (perturb && k == 6) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      check({name, " done_cycle"}, 32'(done_at), 32'(exp_done));
      check({name, " write_count"}, 32'(writes), 32'(exp_writes));
      check({name, " missing_writes"}, 32'(exp_q.size()), 32'd0);
      if (exp_writes > 0 && px0 < 640 && py0 < 480)
         check({name, " first_we_cycle"}, 32'(first_we), 32'd2);
   endtask

   task automatic reset_mid_blit();
      int s, bad;
      drive_start(0, 0, 30, 20, 1, 1, 0);
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc - s < 49) @(negedge clk);
      check("rst pre_we", 32'(fb_we), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst fb_we", 32'(fb_we), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst rom_addr", 32'(rom_addr), 32'd0);
      check("rst state", 32'(state_dbg), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (fb_we || done || busy) bad++;
      end
      check("rst quiet_after", 32'(bad), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0;
      for (int i = 0; i < 65536; i++) rom[i] = 12'(i * 3 + 1);
      rst_n = 1'b0; start = 1'b0;
      posx = '0; posy = '0; width = '0; height = '0;
      memory_start_addr = '0; scaleX = '0; scaleY = '0;
      repeat (3) @(negedge clk);
      check("reset fb_we", 32'(fb_we), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset rom_addr", 32'(rom_addr), 32'd0);
      check("reset fb_addr", 32'(fb_addr), 32'd0);
      check("reset fb_data", 32'(fb_data), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_blit("basic", 0, 0, 30, 20, 1, 1, 0, 600, 602, 1'b0);
      @(negedge clk);
      run_blit("scale3x2", 0, 0, 2, 2, 3, 2, 0, 24, 26, 1'b0);
      @(negedge clk);
      run_blit("scale0", 10, 10, 3, 2, 0, 0, 100, 6, 8, 1'b0);
      @(negedge clk);
      run_blit("clip", 630, 470, 20, 20, 1, 1, 0, 100, 402, 1'b0);
      @(negedge clk);
      run_blit("restart_ignored", 100, 50, 10, 4, 1, 1, 40, 40, 42, 1'b1);
      @(negedge clk);
      run_blit("zero_w", 5, 5, 0, 7, 1, 1, 0, 0, 2, 1'b0);
      @(negedge clk);
      run_blit("zero_h", 5, 5, 7, 0, 2, 2, 0, 0, 2, 1'b0);
      @(negedge clk);
      run_blit("addr_wrap", 0, 0, 4, 2, 1, 1, 16'hFFFE, 8, 10, 1'b0);
      // second blit starts in the very cycle the first one pulses done
      run_blit("b2b_second", 200, 100, 5, 3, 2, 1, 300, 30, 32, 1'b0);
      @(negedge clk);
      reset_mid_blit();
      run_blit("after_reset", 0, 0, 30, 20, 1, 1, 0, 600, 602, 1'b0);
`ifdef SPRITE_BLIT_TRANSPARENT_EN
      @(negedge clk);
      rom[5] = 12'hF0F;
      run_blit("colour_key", 0, 0, 30, 20, 1, 1, 0, 599, 602, 1'b0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
